// File: rtl/sparse_flag_encoder_if.sv
// Handshake bundle between a dense-value producer, the sparse flag encoder and
// its two downstream consumers (packed values and completed flag words).
interface sparse_flag_encoder_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int ADDR_WIDTH  = 5
);
  logic                   clr;
  logic                   in_vld;
  logic                   in_rdy;
  logic [DATA_WIDTH-1:0]  in_dat;
  logic                   out_vld;
  logic                   out_rdy;
  logic [DATA_WIDTH-1:0]  out_dat;
  logic                   flg_vld;
  logic                   flg_rdy;
  logic [BLOCK_DEPTH-1:0] flg_dat;
  logic [ADDR_WIDTH:0]    flg_cnt;

  modport master (
    output clr, in_vld, in_dat, out_rdy, flg_rdy,
    input  in_rdy, out_vld, out_dat, flg_vld, flg_dat, flg_cnt
  );

  modport slave (
    input  clr, in_vld, in_dat, out_rdy, flg_rdy,
    output in_rdy, out_vld, out_dat, flg_vld, flg_dat, flg_cnt
  );
endinterface

// File: rtl/sparse_flag_encoder.sv
// Packs a dense block into nonzero values (1-cycle latency) plus a flag word/popcount;
// input stalls on a full value register, or at the last element while a flag word is pending.
module sparse_flag_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int ADDR_WIDTH  = 5
) (
  input logic                  clk,
  input logic                  rst,
  sparse_flag_encoder_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BLOCK_DEPTH - 1);

  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [BLOCK_DEPTH-1:0] flag_q, flag_d, flag_nxt;
  logic [ADDR_WIDTH:0]    cnt_q, cnt_d, cnt_nxt;
  logic                   out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]  out_dat_q, out_dat_d;
  logic                   flg_vld_q, flg_vld_d;
  logic [BLOCK_DEPTH-1:0] flg_dat_q, flg_dat_d;
  logic [ADDR_WIDTH:0]    flg_cnt_q, flg_cnt_d;
  logic                   in_rdy;
  logic                   accept;
  logic                   nz;

  // Only the closing element needs the flag register free; earlier elements of
  // the next block may accumulate while the previous word waits.
  assign in_rdy = ~rst & (~out_vld_q | bus.out_rdy)
                & ~((idx_q == LAST_IDX) & flg_vld_q & ~bus.flg_rdy);
  assign accept = bus.in_vld & in_rdy & ~bus.clr;
  assign nz     = |bus.in_dat;

  always_comb begin
    flag_nxt        = flag_q;
    flag_nxt[idx_q] = nz;
    cnt_nxt         = cnt_q + (ADDR_WIDTH+1)'(nz);
  end

  always_comb begin
    idx_d     = idx_q;
    flag_d    = flag_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q & ~bus.out_rdy;
    out_dat_d = out_dat_q;
    flg_vld_d = flg_vld_q & ~bus.flg_rdy;
    flg_dat_d = flg_dat_q;
    flg_cnt_d = flg_cnt_q;
    if (bus.clr) begin
      idx_d  = '0;
      flag_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      if (nz) begin
        out_vld_d = 1'b1;
        out_dat_d = bus.in_dat;
      end
      if (idx_q == LAST_IDX) begin
        flg_vld_d = 1'b1;
        flg_dat_d = flag_nxt;
        flg_cnt_d = cnt_nxt;
        idx_d     = '0;
        flag_d    = '0;
        cnt_d     = '0;
      end else begin
        idx_d  = idx_q + 1'b1;
        flag_d = flag_nxt;
        cnt_d  = cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      flag_q    <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      flg_vld_q <= 1'b0;
      flg_dat_q <= '0;
      flg_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      flg_vld_q <= flg_vld_d;
      flg_dat_q <= flg_dat_d;
      flg_cnt_q <= flg_cnt_d;
    end
  end

  assign bus.in_rdy  = in_rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.out_dat = out_dat_q;
  assign bus.flg_vld = flg_vld_q;
  assign bus.flg_dat = flg_dat_q;
  assign bus.flg_cnt = flg_cnt_q;
endmodule

// File: tb/tb_sparse_flag_encoder.sv
// Bench for sparse_flag_encoder: block vector table, hand-written corner sequences,
// and randomized blocks checked by a queue-based reference model.
module tb_sparse_flag_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sparse_flag_encoder_if bus_if ();

  sparse_flag_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [31:0][7:0] v;
    logic             tog;
    logic [31:0]      ef;
    logic [5:0]       ec;
  } vec_t;

  vec_t vecs [4];

  int tests_run    = 0;
  int tests_failed = 0;
  int rdy_mode     = 0;
  int n_out        = 0;
  int flg_hi       = 0;

  logic [7:0]  exp_out [$];
  logic [37:0] exp_flg [$];
  logic [7:0]  cur_blk [$];
  logic [31:0] hist_dat [$];
  logic [5:0]  hist_cnt [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference model and scoreboard: tracks accepted elements per block and
  // derives the expected packed stream and flag words from block contents.
  initial begin
    logic [37:0] e;
    logic [31:0] f;
    int          c;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_out.delete();
        exp_flg.delete();
        cur_blk.delete();
      end else begin
        if (bus_if.out_vld && bus_if.out_rdy) begin
          n_out++;
          if (exp_out.size() == 0) fail_now("out_extra");
          else chk("out_dat", 64'(bus_if.out_dat), 64'(exp_out.pop_front()));
        end
        if (bus_if.flg_vld) flg_hi++;
        if (bus_if.flg_vld && bus_if.flg_rdy) begin
          hist_dat.push_back(bus_if.flg_dat);
          hist_cnt.push_back(bus_if.flg_cnt);
          if (exp_flg.size() == 0) fail_now("flg_extra");
          else begin
            e = exp_flg.pop_front();
            chk("flg_dat", 64'(bus_if.flg_dat), 64'(e[37:6]));
            chk("flg_cnt", 64'(bus_if.flg_cnt), 64'(e[5:0]));
          end
        end
        if (bus_if.clr) cur_blk.delete();
        else if (bus_if.in_vld && bus_if.in_rdy) begin
          cur_blk.push_back(bus_if.in_dat);
          if (bus_if.in_dat != 8'd0) exp_out.push_back(bus_if.in_dat);
          if (cur_blk.size() == 32) begin
            f = 32'd0;
            c = 0;
            for (int i = 0; i < 32; i++) begin
              if (cur_blk[i] != 8'd0) begin
                f = f + (32'd1 << i);
                c = c + 1;
              end
            end
            exp_flg.push_back({f, 6'(c)});
            cur_blk.delete();
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: bus_if.out_rdy = ~bus_if.out_rdy;
        2: begin
          bus_if.out_rdy = 1'($urandom_range(0, 1));
          bus_if.flg_rdy = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
    end
  end

  task automatic rdy_fixed(input logic o, input logic f);
    rdy_mode = 0;
    @(posedge clk);
    #2;
    bus_if.out_rdy = o;
    bus_if.flg_rdy = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v, input int clr_pct, output int stalls);
    bit done = 0;
    stalls = 0;
    bus_if.in_vld = 1'b1;
    bus_if.in_dat = v;
    while (!done) begin
      bus_if.clr = (clr_pct > 0) && ($urandom_range(0, 99) < clr_pct);
      @(negedge clk);
      if (bus_if.in_rdy && !bus_if.clr) done = 1;
      else stalls++;
      @(posedge clk);
      #1;
      if (!done && stalls > 300) begin
        fail_now("send_timeout");
        done = 1;
      end
    end
    bus_if.in_vld = 1'b0;
    bus_if.clr    = 1'b0;
  endtask

  task automatic send_block(input logic [31:0][7:0] v, output int stalls);
    int s;
    stalls = 0;
    for (int k = 0; k < 32; k++) begin
      send(v[k], 0, s);
      stalls += s;
    end
  endtask

  task automatic wait_hist(input int n);
    int cyc = 0;
    while (hist_dat.size() < n && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (hist_dat.size() < n) fail_now("flag_word_timeout");
  endtask

  initial begin
    int               s, h0, o0, f0;
    logic [31:0][7:0] blk;
    bus_if.clr     = 1'b0;
    bus_if.in_vld  = 1'b0;
    bus_if.in_dat  = 8'd0;
    bus_if.out_rdy = 1'b1;
    bus_if.flg_rdy = 1'b1;

    for (int i = 0; i < 4; i++) vecs[i] = '0;
    vecs[0].v[2]  = 8'h05;
    vecs[0].v[31] = 8'h7F;
    vecs[0].ef    = 32'h8000_0004;
    vecs[0].ec    = 6'd2;
    vecs[1].ef    = 32'h0000_0000;
    vecs[1].ec    = 6'd0;
    for (int k = 0; k < 32; k++) vecs[2].v[k] = 8'(k + 1);
    vecs[2].tog   = 1'b1;
    vecs[2].ef    = 32'hFFFF_FFFF;
    vecs[2].ec    = 6'd32;
    for (int k = 0; k < 32; k += 2) vecs[3].v[k] = 8'h80 | 8'(k);
    vecs[3].ef    = 32'h5555_5555;
    vecs[3].ec    = 6'd16;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_rdy",  64'(bus_if.in_rdy),  64'd0);
    chk("rst_out_vld", 64'(bus_if.out_vld), 64'd0);
    chk("rst_out_dat", 64'(bus_if.out_dat), 64'd0);
    chk("rst_flg_vld", 64'(bus_if.flg_vld), 64'd0);
    chk("rst_flg_dat", 64'(bus_if.flg_dat), 64'd0);
    chk("rst_flg_cnt", 64'(bus_if.flg_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].tog) rdy_mode = 1;
      h0 = hist_dat.size();
      o0 = n_out;
      f0 = flg_hi;
      send_block(vecs[i].v, s);
      rdy_fixed(1'b1, 1'b1);
      wait_hist(h0 + 1);
      idle(4);
      chk("vec_flg_dat", 64'(hist_dat[hist_dat.size()-1]), 64'(vecs[i].ef));
      chk("vec_flg_cnt", 64'(hist_cnt[hist_cnt.size()-1]), 64'(vecs[i].ec));
      chk("vec_out_count", 64'(n_out - o0), 64'(vecs[i].ec));
      chk("vec_words", 64'(hist_dat.size() - h0), 64'd1);
      if (i == 0) chk("flg_vld_one_cycle", 64'(flg_hi - f0), 64'd1);
      if (i == 1) chk("zero_blk_no_stall", 64'(s), 64'd0);
      if (vecs[i].tog) chk("toggle_stalls_seen", 64'(s > 0), 64'd1);
    end

    // Back-to-back blocks with the flag consumer stalled.
    rdy_fixed(1'b1, 1'b0);
    h0  = hist_dat.size();
    blk = '0;
    blk[0] = 8'h11;
    send_block(blk, s);
    blk = '0;
    blk[1] = 8'h33;
    for (int k = 0; k < 31; k++) send(blk[k], 0, s);
    bus_if.in_vld = 1'b1;
    bus_if.in_dat = 8'h22;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("b2b_stall_at_last", 64'(bus_if.in_rdy), 64'd0);
      @(posedge clk);
      #1;
    end
    bus_if.flg_rdy = 1'b1;
    @(negedge clk);
    chk("b2b_release", 64'(bus_if.in_rdy), 64'd1);
    @(posedge clk);
    #1;
    bus_if.in_vld = 1'b0;
    wait_hist(h0 + 2);
    idle(3);
    chk("b2b_words", 64'(hist_dat.size() - h0), 64'd2);
    chk("b2b_word1", 64'(hist_dat[h0]),   64'h0000_0001);
    chk("b2b_cnt1",  64'(hist_cnt[h0]),   64'd1);
    chk("b2b_word2", 64'(hist_dat[h0+1]), 64'h8000_0002);
    chk("b2b_cnt2",  64'(hist_cnt[h0+1]), 64'd2);

    // Abort a partial block, with the clr cycle also carrying a dropped element.
    h0  = hist_dat.size();
    blk = '0;
    blk[2] = 8'h0A;
    blk[5] = 8'h0B;
    blk[7] = 8'h0C;
    for (int k = 0; k < 10; k++) send(blk[k], 0, s);
    bus_if.clr    = 1'b1;
    bus_if.in_vld = 1'b1;
    bus_if.in_dat = 8'h55;
    @(posedge clk);
    #1;
    bus_if.clr    = 1'b0;
    bus_if.in_vld = 1'b0;
    blk = '0;
    blk[3]  = 8'h44;
    blk[20] = 8'h99;
    send_block(blk, s);
    wait_hist(h0 + 1);
    idle(3);
    chk("clr_words", 64'(hist_dat.size() - h0), 64'd1);
    chk("clr_flg_dat", 64'(hist_dat[h0]), 64'h0010_0008);
    chk("clr_flg_cnt", 64'(hist_cnt[h0]), 64'd2);

    // Reset pulse with both output registers occupied.
    rdy_fixed(1'b1, 1'b0);
    blk = '0;
    blk[0] = 8'h01;
    send_block(blk, s);
    rdy_fixed(1'b0, 1'b0);
    send(8'h66, 0, s);
    bus_if.in_vld = 1'b1;
    bus_if.in_dat = 8'h67;
    @(negedge clk);
    chk("pre_rst_out_vld", 64'(bus_if.out_vld), 64'd1);
    chk("pre_rst_flg_vld", 64'(bus_if.flg_vld), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", 64'(bus_if.out_vld), 64'd0);
    chk("arst_out_dat", 64'(bus_if.out_dat), 64'd0);
    chk("arst_flg_vld", 64'(bus_if.flg_vld), 64'd0);
    chk("arst_flg_dat", 64'(bus_if.flg_dat), 64'd0);
    chk("arst_flg_cnt", 64'(bus_if.flg_cnt), 64'd0);
    chk("arst_in_rdy",  64'(bus_if.in_rdy),  64'd0);
    bus_if.in_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_fixed(1'b1, 1'b1);
    h0  = hist_dat.size();
    blk = '0;
    blk[0]  = 8'h77;
    blk[31] = 8'h88;
    send_block(blk, s);
    wait_hist(h0 + 1);
    idle(3);
    chk("post_rst_words",   64'(hist_dat.size() - h0), 64'd1);
    chk("post_rst_flg_dat", 64'(hist_dat[h0]), 64'h8000_0001);
    chk("post_rst_flg_cnt", 64'(hist_cnt[h0]), 64'd2);

    // Randomized blocks, random backpressure and occasional clr.
    rdy_mode = 2;
    for (int b = 0; b < 24; b++) begin
      int dens = $urandom_range(0, 100);
      for (int k = 0; k < 32; k++) begin
        logic [7:0] v = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 99) >= dens) v = 8'd0;
        send(v, 2, s);
      end
    end
    rdy_fixed(1'b1, 1'b1);
    idle(20);
    chk("final_out_drained", 64'(exp_out.size()), 64'd0);
    chk("final_flg_drained", 64'(exp_flg.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end
endmodule
